// File: rtl/clk_div_pkg.sv
// Shared defaults and the divisor type for the clock-divider bank.
package clk_div_pkg;

  localparam int          CNT_W       = 25;
  localparam int unsigned DEFAULT_DIV = 8333333;

  typedef logic [CNT_W-1:0] div_t;

endpackage : clk_div_pkg

// File: rtl/clk_div_bank_if.sv
// Control/status bundle between a host and the clock-divider bank.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 25
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic              sync_restart;
  logic [NUM_CH-1:0] out_clk;
  logic [NUM_CH-1:0] tick;

  modport master (
    output ch_en, wr_en, wr_ch, wr_div, sync_restart,
    input  out_clk, tick
  );

  modport slave (
    input  ch_en, wr_en, wr_ch, wr_div, sync_restart,
    output out_clk, tick
  );

endinterface : clk_div_bank_if

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor,
// toggling output clock and a tick on every rising edge of that clock.
module clk_div_chan #(
  parameter int          CNT_W       = 25,
  parameter int unsigned DEFAULT_DIV = 8333333
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             out_clk,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    out_d      = out_q;
    tick_d     = 1'b0;

    if (restart) begin
      cnt_d = '0;
      out_d = 1'b0;
      // A write coinciding with restart takes effect immediately.
      if (wr_hit) begin
        div_act_d  = wr_div;
        div_pend_d = wr_div;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        div_act_d  = div_pend_q;
        pend_vld_d = 1'b0;
      end
    end else begin
      if (en) begin
        if (cnt_q == div_act_q) begin
          cnt_d  = '0;
          out_d  = ~out_q;
          tick_d = ~out_q;
          if (pend_vld_q) begin
            div_act_d  = div_pend_q;
            pend_vld_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Placed after the wrap so a same-cycle write stays pending.
      if (wr_hit) begin
        div_pend_d = wr_div;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      pend_vld_q <= 1'b0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
    end
  end

  assign out_clk = out_q;
  assign tick    = tick_q;

endmodule : clk_div_chan

// File: rtl/clk_div_bank.sv
// Multi-channel clock divider bank: write decode and restart fan-out
// around NUM_CH independent divider channels.
module clk_div_bank #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = clk_div_pkg::CNT_W,
  parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic          inp_clk,
  input  logic          rst,
  clk_div_bank_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] wr_hit;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Out-of-range channel numbers match no channel and are dropped.
      assign wr_hit[gi] = bus.wr_en && (bus.wr_ch == CH_W'(gi));

      clk_div_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk     (inp_clk),
        .rst     (rst),
        .en      (bus.ch_en[gi]),
        .restart (bus.sync_restart),
        .wr_hit  (wr_hit[gi]),
        .wr_div  (bus.wr_div),
        .out_clk (bus.out_clk[gi]),
        .tick    (bus.tick[gi])
      );
    end
  endgenerate

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios then random
// traffic, all compared against a half-period countdown model.
module tb_clk_div_bank;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int DEF    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .inp_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: cycles left in the current half-period, rather than a count-up.
  int m_left [NUM_CH];
  int m_act  [NUM_CH];
  int m_pend [NUM_CH];
  bit m_pv   [NUM_CH];
  bit m_out  [NUM_CH];
  bit m_tk   [NUM_CH];

  task automatic check(input string tag, input logic [NUM_CH-1:0] obs,
                       input logic [NUM_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      bit hit;
      hit = bus.wr_en && (int'(bus.wr_ch) == i);
      if (rst) begin
        m_act[i] = DEF; m_pend[i] = DEF; m_pv[i] = 0;
        m_out[i] = 0;   m_tk[i] = 0;     m_left[i] = DEF + 1;
      end else if (bus.sync_restart) begin
        m_out[i] = 0; m_tk[i] = 0;
        if (hit) begin
          m_act[i] = int'(bus.wr_div); m_pend[i] = m_act[i]; m_pv[i] = 0;
        end else if (m_pv[i]) begin
          m_act[i] = m_pend[i]; m_pv[i] = 0;
        end
        m_left[i] = m_act[i] + 1;
      end else begin
        m_tk[i] = 0;
        if (bus.ch_en[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_out[i] = !m_out[i];
            m_tk[i]  = m_out[i];
            if (m_pv[i]) begin
              m_act[i] = m_pend[i]; m_pv[i] = 0;
            end
            m_left[i] = m_act[i] + 1;
          end
        end
        if (hit) begin
          m_pend[i] = int'(bus.wr_div); m_pv[i] = 1;
        end
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_out();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_out[i];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_tk[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model_out_clk", bus.out_clk, exp_out());
    check("model_tick", bus.tick, exp_tick());
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst              = 1'b1;
    bus.ch_en        = '0;
    bus.wr_en        = 1'b0;
    bus.wr_ch        = '0;
    bus.wr_div       = '0;
    bus.sync_restart = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_pv[i] = 0;
      m_out[i] = 0; m_tk[i] = 0;   m_left[i] = 1;
    end

    steps(2);
    check("reset_out_clk", bus.out_clk, 5'b00000);
    check("reset_tick", bus.tick, 5'b00000);

    // ch0 at default divisor 3: first rise on the 4th edge
    rst       = 1'b0;
    bus.ch_en = 5'b00001;
    steps(3);
    check("ch0_before_rise", bus.out_clk, 5'b00000);
    step();
    check("ch0_first_rise", bus.out_clk, 5'b00001);
    check("ch0_first_tick", bus.tick, 5'b00001);
    step();
    check("ch0_tick_single", bus.tick, 5'b00000);

    // ch0 at cnt=1: write divisor 1, current half-period must finish at 4
    bus.wr_en = 1'b1; bus.wr_ch = 3'd0; bus.wr_div = 8'd1;
    step();
    bus.wr_en = 1'b0;
    step();
    check("ch0_old_half_held", bus.out_clk, 5'b00001);
    step();
    check("ch0_old_half_end", bus.out_clk, 5'b00000);
    step();
    check("ch0_new_half_low", bus.out_clk, 5'b00000);
    step();
    check("ch0_new_half_rise", bus.out_clk, 5'b00001);
    steps(8);

    // ch1 divisor 0: toggles every cycle once applied
    bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_div = 8'd0;
    step();
    bus.wr_en = 1'b0;
    bus.ch_en = 5'b00011;
    steps(12);

    // ch2 paused at cnt=2 for 10 cycles, then resumed
    bus.sync_restart = 1'b1;
    step();
    bus.sync_restart = 1'b0;
    bus.ch_en = 5'b00111;
    steps(2);
    bus.ch_en = 5'b00011;
    steps(10);
    bus.ch_en = 5'b00111;
    steps(10);

    // restart with a simultaneous write to ch3
    bus.ch_en = 5'b11111;
    steps(7);
    bus.sync_restart = 1'b1;
    bus.wr_en = 1'b1; bus.wr_ch = 3'd3; bus.wr_div = 8'd5;
    step();
    bus.sync_restart = 1'b0;
    bus.wr_en = 1'b0;
    check("restart_out_clk", bus.out_clk, 5'b00000);
    check("restart_tick", bus.tick, 5'b00000);
    steps(5);
    check("ch3_half6_low", {4'b0, bus.out_clk[3]}, 5'b00000);
    step();
    check("ch3_half6_rise", {4'b0, bus.out_clk[3]}, 5'b00001);
    steps(14);

    // out-of-range write, then reset mid-period
    bus.wr_en = 1'b1; bus.wr_ch = 3'd5; bus.wr_div = 8'd0;
    step();
    bus.wr_en = 1'b0;
    steps(5);
    rst = 1'b1;
    step();
    check("rst_mid_out_clk", bus.out_clk, 5'b00000);
    check("rst_mid_tick", bus.tick, 5'b00000);
    rst = 1'b0;
    steps(3);
    check("post_rst_default_low", bus.out_clk, 5'b00000);
    step();
    check("post_rst_default_rise", bus.out_clk, 5'b11111);
    steps(10);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.ch_en        = NUM_CH'($urandom | $urandom);
      bus.wr_en        = ($urandom_range(0, 3) == 0);
      bus.wr_ch        = 3'($urandom_range(0, 7));
      bus.wr_div       = 8'($urandom_range(0, 6));
      bus.sync_restart = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clk_div_bank
